rbcp_wb_bridge: RTL and testbench

Parametrised RBCP-to-Wishbone master bridge. It converts single-byte SiTCP RBCP read and write requests into Wishbone classic cycles on a bus of 8, 16 or 32 bits, steering the byte onto the correct lane. Compared with the fixed 8-bit converter it adds retry handling, a transaction watchdog and an error status output. It sits between the SiTCP RBCP port and the on-board Wishbone register fabric.

---
 rtl/rbcp_wb_pkg.sv | 20 ++
 rtl/rbcp_wb_bridge_if.sv | 26 ++
 rtl/rbcp_wb_watchdog.sv | 29 ++
 rtl/rbcp_wb_bridge.sv | 148 ++++++++++++++
 tb/tb_rbcp_wb_bridge.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rbcp_wb_pkg.sv
// Shared types and constants for the RBCP-to-Wishbone bridge.
package rbcp_wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    BACKOFF = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SLAVE   = 2'b01;
  localparam logic [1:0] ERR_RETRY   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Number of address bits that select a byte lane within one bus word.
  function automatic int lane_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/rbcp_wb_bridge_if.sv
// Wishbone classic bus between the bridge (master) and the register fabric (slave).
interface rbcp_wb_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   wb_adr;
  logic [DATA_W-1:0]   wb_dat_o;
  logic [DATA_W-1:0]   wb_dat_i;
  logic                wb_cyc;
  logic                wb_stb;
  logic                wb_we;
  logic [DATA_W/8-1:0] wb_sel;
  logic                wb_ack;
  logic                wb_err;
  logic                wb_rty;

  modport master (
    output wb_adr, wb_dat_o, wb_cyc, wb_stb, wb_we, wb_sel,
    input  wb_dat_i, wb_ack, wb_err, wb_rty
  );

  modport slave (
    input  wb_adr, wb_dat_o, wb_cyc, wb_stb, wb_we, wb_sel,
    output wb_dat_i, wb_ack, wb_err, wb_rty
  );
endinterface

// File: rtl/rbcp_wb_watchdog.sv
// Transaction watchdog: reloads to TIMEOUT-1 on clr, counts down while en,
// and flags expiry once TIMEOUT enabled cycles have elapsed since the reload.
module rbcp_wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= CW'(TIMEOUT - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = en && (cnt == '0);

endmodule

// File: rtl/rbcp_wb_bridge.sv
// Single-byte RBCP to Wishbone classic master with lane steering, retry and error status.
// Optional watchdog enabled by defining RBCP_WB_TIMEOUT_EN.
module rbcp_wb_bridge
  import rbcp_wb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rbcp_act,
  input  logic                  rbcp_we,
  input  logic                  rbcp_re,
  input  logic [31:0]           rbcp_addr,
  input  logic [7:0]            rbcp_wd,
  output logic [7:0]            rbcp_rd,
  output logic                  rbcp_ack,
  rbcp_wb_bridge_if.master      wb,
  output logic                  err_o,
  output logic [1:0]            err_code
);

  localparam int LB = lane_bits(DATA_W);
  localparam int LW = (LB > 0) ? LB : 1;
  localparam int NS = DATA_W / 8;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [ADDR_W-1:0] ADR_MASK = ~(ADDR_W'((1 << LB) - 1));

  state_t          state, state_nxt;
  logic [ADDR_W-1:0] adr_q;
  logic [7:0]      wd_q;
  logic            we_q;
  logic [LW-1:0]   lane_q;
  logic [LW-1:0]   lane_in;
  logic [RW-1:0]   retry_cnt;
  logic            retry_ok;
  logic            capture;
  logic            expire;
  logic [7:0]      rd_byte;

  assign capture  = (state == IDLE) && (rbcp_we || rbcp_re);
  assign retry_ok = int'(retry_cnt) < MAX_RETRY;
  assign rd_byte  = wb.wb_dat_i[{lane_q, 3'b000} +: 8];

  generate
    if (LB > 0) begin : g_lane
      assign lane_in = rbcp_addr[LW-1:0];
    end else begin : g_no_lane
      assign lane_in = '0;
    end
  endgenerate

`ifdef RBCP_WB_TIMEOUT_EN
  // Runs through BACKOFF so retries cannot extend the overall access deadline.
  rbcp_wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (capture),
    .en     (state != IDLE),
    .expire (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A dropped rbcp_act overrides any slave response: the host has given up.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rbcp_we || rbcp_re) state_nxt = BUS;
      end
      BUS: begin
        if (!rbcp_act)                  state_nxt = IDLE;
        else if (wb.wb_ack || wb.wb_err) state_nxt = IDLE;
        else if (wb.wb_rty)             state_nxt = retry_ok ? BACKOFF : IDLE;
        else if (expire)                state_nxt = IDLE;
      end
      BACKOFF: begin
        state_nxt = rbcp_act ? BUS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb.wb_cyc   = (state == BUS);
    wb.wb_stb   = (state == BUS);
    wb.wb_we    = (state == BUS) && we_q;
    wb.wb_sel   = (state == BUS) ? (NS'(1) << lane_q) : '0;
    wb.wb_adr   = adr_q;
    wb.wb_dat_o = {NS{wd_q}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q     <= '0;
      wd_q      <= '0;
      we_q      <= 1'b0;
      lane_q    <= '0;
      retry_cnt <= '0;
      rbcp_rd   <= 8'h00;
      rbcp_ack  <= 1'b0;
      err_o     <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      rbcp_ack <= 1'b0;
      err_o    <= 1'b0;
      if (capture) begin
        adr_q     <= rbcp_addr[ADDR_W-1:0] & ADR_MASK;
        wd_q      <= rbcp_wd;
        we_q      <= rbcp_we;
        lane_q    <= lane_in;
        retry_cnt <= '0;
      end
      if (state == BUS && rbcp_act) begin
        if (wb.wb_ack) begin
          rbcp_ack <= 1'b1;
          if (!we_q) rbcp_rd <= rd_byte;
        end else if (wb.wb_err) begin
          err_o    <= 1'b1;
          err_code <= ERR_SLAVE;
        end else if (wb.wb_rty) begin
          if (retry_ok) begin
            retry_cnt <= retry_cnt + RW'(1);
          end else begin
            err_o    <= 1'b1;
            err_code <= ERR_RETRY;
          end
        end else if (expire) begin
          err_o    <= 1'b1;
          err_code <= ERR_TIMEOUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_rbcp_wb_bridge.sv
// Scoreboard bench for rbcp_wb_bridge with a registered-response Wishbone slave model.
module tb_rbcp_wb_bridge;
  import rbcp_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rbcp_act, rbcp_we, rbcp_re;
  logic [31:0] rbcp_addr;
  logic [7:0]  rbcp_wd;
  logic [7:0]  rbcp_rd;
  logic        rbcp_ack;
  logic        err_o;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  rbcp_wb_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rbcp_wb_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_RETRY(3), .TIMEOUT(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .rbcp_act  (rbcp_act),
    .rbcp_we   (rbcp_we),
    .rbcp_re   (rbcp_re),
    .rbcp_addr (rbcp_addr),
    .rbcp_wd   (rbcp_wd),
    .rbcp_rd   (rbcp_rd),
    .rbcp_ack  (rbcp_ack),
    .wb        (bus),
    .err_o     (err_o),
    .err_code  (err_code)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Slave model: mode 0 ack, 1 err, 2 silent; first rty_cfg attempts answered with rty.
  int mode = 0;
  int rty_cfg = 0;
  int rty_given = 0;

  always @(posedge clk) begin
    bus.wb_ack <= 1'b0;
    bus.wb_err <= 1'b0;
    bus.wb_rty <= 1'b0;
    if (rbcp_we || rbcp_re) rty_given <= 0;
    if (bus.wb_cyc && bus.wb_stb && !bus.wb_ack && !bus.wb_err && !bus.wb_rty) begin
      if (rty_given < rty_cfg) begin
        bus.wb_rty <= 1'b1;
        rty_given  <= rty_given + 1;
      end else if (mode == 0) begin
        bus.wb_ack <= 1'b1;
      end else if (mode == 1) begin
        bus.wb_err <= 1'b1;
      end
    end
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Bus activity monitor.
  logic        cyc_prev = 1'b0;
  logic        cyc_seen = 1'b0;
  int          attempts = 0, hi_cyc = 0, gap_cyc = 0;
  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we;

  always @(negedge clk) begin
    if (rbcp_we || rbcp_re) cyc_seen = 1'b0;
    if (bus.wb_cyc && !cyc_prev) begin
      attempts++;
      cyc_seen = 1'b1;
      cap_adr  = bus.wb_adr;
      cap_dat  = bus.wb_dat_o;
      cap_sel  = bus.wb_sel;
      cap_we   = bus.wb_we;
    end
    if (bus.wb_cyc) hi_cyc++;
    else if (cyc_seen && !rbcp_ack && !err_o) gap_cyc++;
    cyc_prev = bus.wb_cyc;
  end

  // Scoreboard.
  typedef struct {
    bit         is_err;
    logic [7:0] rd;
    logic [1:0] code;
    int         lat;
    int         issue;
    string      name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   resp_cnt = 0;

  always @(negedge clk) begin
    if (rbcp_ack || err_o) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp got ack=%0b err=%0b want=none", rbcp_ack, err_o);
      end else begin
        mon_e = sbq.pop_front();
        check({mon_e.name, "_kind"}, {30'd0, rbcp_ack, err_o}, mon_e.is_err ? 32'd1 : 32'd2);
        if (mon_e.is_err) check({mon_e.name, "_code"}, {30'd0, err_code}, {30'd0, mon_e.code});
        else              check({mon_e.name, "_rd"}, {24'd0, rbcp_rd}, {24'd0, mon_e.rd});
        check({mon_e.name, "_lat"}, cyc_n - mon_e.issue, mon_e.lat);
      end
      resp_cnt++;
    end
  end

  int a0, h0, g0, r0;

  task automatic issue(input bit we, input bit re, input logic [31:0] addr, input logic [7:0] wd,
                       input bit has_exp, input bit is_err, input logic [7:0] rd,
                       input logic [1:0] code, input int lat, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    a0 = attempts; h0 = hi_cyc; g0 = gap_cyc; r0 = resp_cnt;
    if (has_exp) begin
      e.is_err = is_err; e.rd = rd; e.code = code; e.lat = lat; e.issue = cyc_n; e.name = name;
      sbq.push_back(e);
    end
    rbcp_we = we; rbcp_re = re; rbcp_addr = addr; rbcp_wd = wd;
    @(posedge clk);
    #1;
    rbcp_we = 1'b0; rbcp_re = 1'b0;
  endtask

  task automatic wait_resp(input int maxc, input string name);
    int i;
    for (i = 0; i < maxc; i++) begin
      @(posedge clk);
      if (resp_cnt != r0) break;
    end
    if (i == maxc) begin
      checks++;
      errors++;
      $display("FAIL %s_wait got=no_response want=response within %0d cycles", name, maxc);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=hang want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    rbcp_act = 1'b0; rbcp_we = 1'b0; rbcp_re = 1'b0;
    rbcp_addr = '0; rbcp_wd = '0;
    bus.wb_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", {31'd0, bus.wb_cyc}, 0);
    check("rst_stb", {31'd0, bus.wb_stb}, 0);
    check("rst_we", {31'd0, bus.wb_we}, 0);
    check("rst_sel", {28'd0, bus.wb_sel}, 0);
    check("rst_adr", bus.wb_adr, 0);
    check("rst_dat", bus.wb_dat_o, 0);
    check("rst_rd", {24'd0, rbcp_rd}, 0);
    check("rst_ack", {31'd0, rbcp_ack}, 0);
    check("rst_err", {31'd0, err_o}, 0);
    check("rst_code", {30'd0, err_code}, 0);
    rst = 1'b0;
    rbcp_act = 1'b1;

    // Write 0x5A to 0x106: lane 2.
    issue(1, 0, 32'h0000_0106, 8'h5A, 1, 0, 8'h00, 2'b00, 3, "wr106");
    wait_resp(20, "wr106");
    check("wr106_adr", cap_adr, 32'h104);
    check("wr106_sel", {28'd0, cap_sel}, 32'h4);
    check("wr106_dat", cap_dat, 32'h5A5A5A5A);
    check("wr106_we", {31'd0, cap_we}, 1);

    // Read 0x103 from 0xDDCCBBAA: lane 3.
    bus.wb_dat_i = 32'hDDCCBBAA;
    issue(0, 1, 32'h0000_0103, 8'h00, 1, 0, 8'hDD, 2'b00, 3, "rd103");
    wait_resp(20, "rd103");
    check("rd103_adr", cap_adr, 32'h100);
    check("rd103_sel", {28'd0, cap_sel}, 32'h8);
    check("rd103_we", {31'd0, cap_we}, 0);

    // Read lane 0.
    bus.wb_dat_i = 32'h11223344;
    issue(0, 1, 32'h0000_0200, 8'h00, 1, 0, 8'h44, 2'b00, 3, "rd200");
    wait_resp(20, "rd200");
    check("rd200_sel", {28'd0, cap_sel}, 32'h1);

    // Write keeps rbcp_rd.
    issue(1, 0, 32'h0000_0002, 8'h77, 1, 0, 8'h44, 2'b00, 3, "wr002");
    wait_resp(20, "wr002");
    check("wr002_sel", {28'd0, cap_sel}, 32'h4);
    check("wr002_dat", cap_dat, 32'h77777777);

    // Two retries then ack: lane 1 of 0x11223344.
    rty_cfg = 2;
    issue(0, 1, 32'h0000_0101, 8'h00, 1, 0, 8'h33, 2'b00, 9, "rty2");
    wait_resp(40, "rty2");
    check("rty2_attempts", attempts - a0, 3);
    check("rty2_gaps", gap_cyc - g0, 2);

    // Retries exhausted.
    rty_cfg = 1000;
    issue(0, 1, 32'h0000_0000, 8'h00, 1, 1, 8'h00, ERR_RETRY, 12, "rtyall");
    wait_resp(40, "rtyall");
    check("rtyall_attempts", attempts - a0, 4);

    // Slave error; err_code must hold afterwards.
    rty_cfg = 0;
    mode = 1;
    issue(1, 0, 32'h0000_0010, 8'h12, 1, 1, 8'h00, ERR_SLAVE, 3, "slverr");
    wait_resp(20, "slverr");
    repeat (3) @(posedge clk);
    #1;
    check("slverr_hold", {30'd0, err_code}, {30'd0, ERR_SLAVE});

`ifdef RBCP_WB_TIMEOUT_EN
    mode = 2;
    issue(0, 1, 32'h0000_0004, 8'h00, 1, 1, 8'h00, ERR_TIMEOUT, 256, "tmo");
    wait_resp(400, "tmo");
    check("tmo_hi_cycles", hi_cyc - h0, 255);
`endif

    // Simultaneous strobes (write wins), then abort by dropping rbcp_act.
    mode = 2;
    issue(1, 1, 32'h0000_0021, 8'h3C, 0, 0, 8'h00, 2'b00, 0, "both");
    @(posedge clk);
    #1;
    check("both_cyc_before", {31'd0, bus.wb_cyc}, 1);
    check("both_we", {31'd0, cap_we}, 1);
    check("both_sel", {28'd0, cap_sel}, 32'h2);
    check("both_adr", cap_adr, 32'h20);
    rbcp_act = 1'b0;
    @(posedge clk);
    #1;
    check("abort_cyc", {31'd0, bus.wb_cyc}, 0);
    repeat (3) @(posedge clk);
    #1;
    rbcp_act = 1'b1;
    mode = 0;
    bus.wb_dat_i = 32'hDDCCBBAA;
    issue(0, 1, 32'h0000_0103, 8'h00, 1, 0, 8'hDD, 2'b00, 3, "rdafter");
    wait_resp(20, "rdafter");

    // Asynchronous reset in the middle of a bus cycle.
    mode = 2;
    issue(0, 1, 32'h0000_0008, 8'h00, 0, 0, 8'h00, 2'b00, 0, "rstmid");
    @(posedge clk);
    #3;
    check("rstmid_cyc_before", {31'd0, bus.wb_cyc}, 1);
    rst = 1'b1;
    #1;
    check("rstmid_cyc", {31'd0, bus.wb_cyc}, 0);
    check("rstmid_rd", {24'd0, rbcp_rd}, 0);
    check("rstmid_code", {30'd0, err_code}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode = 0;
    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
